// File: rtl/bcd_uart_tx.sv
// Sends a BCD digit pair as 8N1 ASCII ('0'+tens, '0'+ones, optional CR LF); the start bit begins on the accepting edge.
// in_ready stays low for the whole message; in_valid during that time is ignored and nothing is queued.
module bcd_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit SEND_CRLF    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  output logic       tx,
  output logic       busy,
  output logic       msg_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0] LAST_BYTE = SEND_CRLF ? 2'd3 : 2'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [1:0]    byte_idx, byte_idx_nxt;
  logic [3:0]    tens_q, tens_nxt;
  logic [3:0]    ones_q, ones_nxt;
  logic          tx_nxt, in_ready_nxt, busy_nxt, msg_done_nxt;
  logic          baud_wrap;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
  endfunction

  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      2'd0:    cur_byte = digit_ascii(tens_q);
      2'd1:    cur_byte = digit_ascii(ones_q);
      2'd2:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  assign baud_wrap = (baud_cnt == CNT_MAX);

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_wrap ? '0 : baud_cnt + CW'(1);
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    tens_nxt     = tens_q;
    ones_nxt     = ones_q;
    tx_nxt       = tx;
    in_ready_nxt = in_ready;
    busy_nxt     = busy;
    msg_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        if (in_valid && in_ready) begin
          tens_nxt     = bcd_tens;
          ones_nxt     = bcd_ones;
          byte_idx_nxt = 2'd0;
          bit_idx_nxt  = 3'd0;
          state_nxt    = START;
          tx_nxt       = 1'b0;
          in_ready_nxt = 1'b0;
          busy_nxt     = 1'b1;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
          tx_nxt      = cur_byte[0];
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_idx != 3'd7) begin
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = cur_byte[bit_idx + 3'd1];
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (byte_idx != LAST_BYTE) begin
            // next start bit follows the stop bit with no idle gap
            byte_idx_nxt = byte_idx + 2'd1;
            state_nxt    = START;
            tx_nxt       = 1'b0;
          end else begin
            byte_idx_nxt = 2'd0;
            bit_idx_nxt  = 3'd0;
            state_nxt    = IDLE;
            in_ready_nxt = 1'b1;
            busy_nxt     = 1'b0;
            msg_done_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      msg_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
      tens_q   <= tens_nxt;
      ones_q   <= ones_nxt;
      tx       <= tx_nxt;
      in_ready <= in_ready_nxt;
      busy     <= busy_nxt;
      msg_done <= msg_done_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_uart_tx.sv
// Two instances (CR LF on / off) driven by randomized digit pairs; a negedge monitor decodes the line
// as a UART receiver and compares against a queue of expected bytes and message completion times.
module tb_bcd_uart_tx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid [2];
  logic       in_ready [2];
  logic [3:0] tens     [2];
  logic [3:0] ones     [2];
  logic       tx       [2];
  logic       busy     [2];
  logic       msg_done [2];

  always #5 clk = ~clk;

  bcd_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .bcd_tens(tens[0]), .bcd_ones(ones[0]), .tx(tx[0]), .busy(busy[0]), .msg_done(msg_done[0])
  );

  bcd_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .bcd_tens(tens[1]), .bcd_ones(ones[1]), .tx(tx[1]), .busy(busy[1]), .msg_done(msg_done[1])
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic [7:0] ascii_of(input logic [3:0] d);
    return (d <= 4'd9) ? 8'(48 + int'(d)) : 8'h3F;
  endfunction

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         timed_out = 0;
  bit         final_req = 1'b0;
  bit         final_done = 1'b0;

  logic [7:0] exp_buf [2][8];
  int         wr [2] = '{0, 0};
  int         rd [2] = '{0, 0};
  bit         pend [2] = '{1'b0, 1'b0};
  int         pend_t [2];
  bit         rx_act [2] = '{1'b0, 1'b0};
  int         k [2];
  logic [7:0] rx_byte [2];
  bit         prev_rst = 1'b0;
  bit         exp_rdy;
  bit         done_exp;
  int         j;

  task automatic check(input bit ok, input string name, input int i, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc=%0d actual=%0h required=%0h", name, i, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        if (prev_rst) begin
          check(tx[i] === 1'b1, "rst_tx", i, int'(tx[i]), 1);
          check(in_ready[i] === 1'b1, "rst_in_ready", i, int'(in_ready[i]), 1);
          check(msg_done[i] === 1'b0, "rst_msg_done", i, int'(msg_done[i]), 0);
        end
        rx_act[i] = 1'b0;
        pend[i]   = 1'b0;
        rd[i]     = wr[i];
      end else begin
        if (prev_rst) begin
          check(tx[i] === 1'b1, "post_rst_tx", i, int'(tx[i]), 1);
          check(busy[i] === 1'b0, "post_rst_busy", i, int'(busy[i]), 0);
          check(msg_done[i] === 1'b0, "post_rst_msg_done", i, int'(msg_done[i]), 0);
        end
        exp_rdy = !(pend[i] && cyc < pend_t[i]);
        check(in_ready[i] === exp_rdy, "in_ready", i, int'(in_ready[i]), int'(exp_rdy));
        check(busy[i] === !exp_rdy, "busy", i, int'(busy[i]), int'(!exp_rdy));
        done_exp = pend[i] && (cyc == pend_t[i]);
        check(msg_done[i] === done_exp, "msg_done", i, int'(msg_done[i]), int'(done_exp));
        if (done_exp) pend[i] = 1'b0;

        // line decoder: sample each bit in its middle
        if (!rx_act[i] && tx[i] === 1'b0) begin
          rx_act[i] = 1'b1;
          k[i] = 0;
        end
        if (rx_act[i]) begin
          if (k[i] % CPB == CPB / 2) begin
            j = k[i] / CPB;
            if (j == 0) begin
              check(tx[i] === 1'b0, "start_bit", i, int'(tx[i]), 0);
            end else if (j <= 8) begin
              rx_byte[i][j-1] = tx[i];
            end else begin
              check(tx[i] === 1'b1, "stop_bit", i, int'(tx[i]), 1);
              if (rd[i] != wr[i]) begin
                check(rx_byte[i] === exp_buf[i][rd[i] % 8], "byte", i,
                      int'(rx_byte[i]), int'(exp_buf[i][rd[i] % 8]));
                rd[i]++;
              end else begin
                check(1'b0, "unexpected_byte", i, int'(rx_byte[i]), -1);
              end
              rx_act[i] = 1'b0;
            end
          end
          k[i]++;
        end

        // a handshake will happen on the coming edge
        if (in_valid[i] === 1'b1 && !pend[i]) begin
          exp_buf[i][wr[i] % 8] = ascii_of(tens[i]); wr[i]++;
          exp_buf[i][wr[i] % 8] = ascii_of(ones[i]); wr[i]++;
          if (i == 0) begin
            exp_buf[i][wr[i] % 8] = 8'h0D; wr[i]++;
            exp_buf[i][wr[i] % 8] = 8'h0A; wr[i]++;
          end
          pend[i]   = 1'b1;
          pend_t[i] = cyc + 1 + nbytes(i) * 10 * CPB;
        end
      end
    end
    prev_rst = rst;

    if (final_req && !final_done) begin
      for (int i = 0; i < 2; i++) begin
        check(!pend[i], "end_pending", i, int'(pend[i]), 0);
        check(rd[i] == wr[i], "end_bytes_left", i, wr[i] - rd[i], 0);
      end
      check(timed_out == 0, "timeouts", 0, timed_out, 0);
      final_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int i, input logic [3:0] t, input logic [3:0] o);
    in_valid[i] = 1'b1;
    tens[i] = t;
    ones[i] = o;
    for (int w = 0; w < 2000; w++) begin
      @(negedge clk);
      if (in_ready[i] === 1'b1 && !rst) begin
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        return;
      end
    end
    in_valid[i] = 1'b0;
    timed_out++;
    $display("FAIL send_timeout inst%0d actual=no_accept required=accept", i);
  endtask

  task automatic wait_idle(input int i);
    for (int w = 0; w < 2000; w++) begin
      if (!pend[i] && !rx_act[i]) return;
      @(posedge clk);
      #1;
    end
    timed_out++;
    $display("FAIL idle_timeout inst%0d actual=busy required=idle", i);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b1;
      tens[i] = 4'd9;
      ones[i] = 4'd9;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    send(0, 4'd4, 4'd2);
    wait_idle(0);
    send(0, 4'hA, 4'h9);
    repeat (4) @(posedge clk);
    #1;
    send(0, 4'd7, 4'd7);
    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    wait_idle(0);

    for (int v = 0; v < 100; v++) begin
      send(1, 4'(v / 10), 4'(v % 10));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle(1);

    send(0, 4'd5, 4'd5);
    repeat (199) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(0, 4'd1, 4'd3);
    send(1, 4'd1, 4'd3);
    wait_idle(0);
    wait_idle(1);

    final_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
